// File: rtl/adc_axi_pkg.sv
// Shared AXI constants, writer FSM state encoding and a constant-width helper
// for the ADC-to-DDR burst writer.
package adc_axi_pkg;

    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF   = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ADDR,
        DATA,
        RESP
    } wr_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; clr empties it
// in one cycle without touching the storage array.
module sync_fifo
    import adc_axi_pkg::*;
#(
    parameter int  DW    = 32,
    parameter int  DEPTH = 64,
    localparam int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic [PW:0]   count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_idx <= wr_idx + PW'(1);
            if (pop_ok)  rd_idx <= rd_idx + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/adc_axi_burst_writer.sv
// AXI4 write master streaming ADC samples into a circular DDR region in fixed INCR bursts.
// Define ADC_AXI_WR_FLUSH_EN to write residual samples as one short burst on stop.
module adc_axi_burst_writer
    import adc_axi_pkg::*;
#(
    parameter int          C_DATA_WIDTH   = 32,
    parameter int          C_ADDR_WIDTH   = 32,
    parameter int          C_BURST_LEN    = 16,
    parameter int          C_FIFO_DEPTH   = 64,
    parameter logic [31:0] C_BUF_BASEADDR = 32'hA4000000,
    parameter logic [31:0] C_BUF_BYTES    = 32'h04000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [C_DATA_WIDTH-1:0]   s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [3:0]                m_axi_awcache,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic                      busy,
    output logic [C_ADDR_WIDTH-1:0]   wr_ptr,
    output logic [15:0]               wrap_cnt,
    output logic                      overflow,
    output logic                      resp_err
);

    localparam int                    BEAT_BYTES = C_DATA_WIDTH / 8;
    localparam int                    CNT_W      = clog2(C_FIFO_DEPTH) + 1;
    localparam logic [7:0]            LAST_BEAT  = 8'(C_BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      BURST_CNT  = CNT_W'(C_BURST_LEN);
    localparam logic [C_ADDR_WIDTH-1:0] BASE     = C_ADDR_WIDTH'(C_BUF_BASEADDR);
    localparam logic [C_ADDR_WIDTH-1:0] RING_END = BASE + C_ADDR_WIDTH'(C_BUF_BYTES);

    wr_state_t               state;
    logic                    stop_lat;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic [7:0]              beat_cnt;
    logic [7:0]              awlen_cur;
    logic [C_ADDR_WIDTH-1:0] burst_bytes;
    logic [C_ADDR_WIDTH-1:0] next_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    // Capture stops accepting samples once stop is latched so the drain terminates.
    assign s_ready = (state != IDLE) && !stop_lat && !fifo_full;
    assign push    = s_valid && s_ready;
    assign pop     = wvalid_q && m_axi_wready;

    sync_fifo #(
        .DW    (C_DATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == IDLE),
        .push      (push),
        .push_data (s_data),
        .pop       (pop),
        .head      (m_axi_wdata),
        .full      (fifo_full),
        .count     (fifo_cnt)
    );

`ifdef ADC_AXI_WR_FLUSH_EN
    logic [7:0] awlen_q;
    assign awlen_cur = awlen_q;
`else
    assign awlen_cur = LAST_BEAT;
`endif

    assign burst_bytes = C_ADDR_WIDTH'((int'(awlen_cur) + 1) * BEAT_BYTES);
    assign next_ptr    = wr_ptr + burst_bytes;

    assign m_axi_awaddr  = wr_ptr;
    assign m_axi_awlen   = awlen_cur;
    assign m_axi_awsize  = 3'(clog2(BEAT_BYTES));
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awcache = AXI_CACHE_BUF;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wlast   = wvalid_q && (beat_cnt == awlen_cur);
    assign m_axi_bready  = bready_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stop_lat  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            beat_cnt  <= '0;
            wr_ptr    <= BASE;
            wrap_cnt  <= '0;
            overflow  <= 1'b0;
            resp_err  <= 1'b0;
`ifdef ADC_AXI_WR_FLUSH_EN
            awlen_q   <= LAST_BEAT;
`endif
        end else begin
            if (state != IDLE && s_valid && fifo_full) overflow <= 1'b1;
            if (state != IDLE && stop) stop_lat <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        wr_ptr   <= BASE;
                        wrap_cnt <= '0;
                        overflow <= 1'b0;
                        resp_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (fifo_cnt >= BURST_CNT) begin
                        state <= ADDR;
`ifdef ADC_AXI_WR_FLUSH_EN
                        awlen_q <= LAST_BEAT;
`endif
                    end else if (stop_lat) begin
`ifdef ADC_AXI_WR_FLUSH_EN
                        if (fifo_cnt != '0) begin
                            state   <= ADDR;
                            awlen_q <= 8'(fifo_cnt - CNT_W'(1));
                        end else begin
                            state    <= IDLE;
                            stop_lat <= 1'b0;
                        end
`else
                        state    <= IDLE;
                        stop_lat <= 1'b0;
`endif
                    end
                end
                // awvalid is raised one cycle after entry and held until accepted.
                ADDR: begin
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                    end else if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_wready) begin
                        if (beat_cnt == awlen_cur) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp == AXI_RESP_SLVERR || m_axi_bresp == AXI_RESP_DECERR)
                            resp_err <= 1'b1;
                        if (next_ptr == RING_END) begin
                            wr_ptr <= BASE;
                            if (wrap_cnt != 16'hFFFF) wrap_cnt <= wrap_cnt + 16'd1;
                        end else begin
                            wr_ptr <= next_ptr;
                        end
`ifdef ADC_AXI_WR_FLUSH_EN
                        state <= RUN;
`else
                        if (stop_lat) begin
                            state    <= IDLE;
                            stop_lat <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_axi_burst_writer.sv
// Directed-plus-random bench for adc_axi_burst_writer: AXI slave responder, bus monitors
// and a ring-address / sample-order reference model.
module tb_adc_axi_burst_writer;

    localparam logic [31:0] BASE = 32'hA4000000;
    localparam int          RING = 256;
    localparam int          BL   = 16;

    logic        clk = 1'b0;
    logic        rst, start, stop, s_valid, s_ready;
    logic [31:0] s_data;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready, busy;
    logic [31:0] wr_ptr;
    logic [15:0] wrap_cnt;
    logic        overflow, resp_err;

    int errors = 0;
    int checks = 0;

    int aw_delay = 0;
    bit w_toggle = 0;
    bit w_stall  = 0;
    int err_at   = -1;

    logic [31:0] in_q[$];
    logic [31:0] w_q[$];
    logic        wl_q[$];
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          b_cnt = 0;
    int          aw_unstable = 0;
    logic        aw_pend = 1'b0;
    logic [31:0] aw_prev = '0;

    logic [31:0] model_ptr;
    int          model_wraps;

    always #5 clk = ~clk;

    adc_axi_burst_writer #(
        .C_BUF_BYTES (32'd256)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_axi_awaddr  (awaddr),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_awburst (awburst),
        .m_axi_awcache (awcache),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .busy          (busy),
        .wr_ptr        (wr_ptr),
        .wrap_cnt      (wrap_cnt),
        .overflow      (overflow),
        .resp_err      (resp_err)
    );

    // Bus monitors sample on the falling edge, between driver updates and the active edge.
    always @(negedge clk) begin
        if (s_valid && s_ready) in_q.push_back(s_data);
        if (awvalid && awready) begin
            aw_addr_q.push_back(awaddr);
            aw_len_q.push_back(awlen);
        end
        if (aw_pend && (!awvalid || awaddr !== aw_prev)) aw_unstable <= aw_unstable + 1;
        aw_pend <= awvalid && !awready;
        aw_prev <= awaddr;
        if (wvalid && wready) begin
            w_q.push_back(wdata);
            wl_q.push_back(wlast);
        end
        if (bvalid && bready) b_cnt <= b_cnt + 1;
    end

    // AXI slave responder: configurable AW delay, W stall/toggle, error on a chosen response.
    initial begin
        int aw_wait;
        int b_issued;
        aw_wait  = 0;
        b_issued = 0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (awvalid && !awready) begin
                awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                awready = 1'b0;
                aw_wait = 0;
            end
            if (w_stall)       wready = 1'b0;
            else if (w_toggle) wready = !wready;
            else               wready = 1'b1;
            if (bvalid) begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end else if (bready) begin
                bvalid = 1'b1;
                bresp  = (b_issued == err_at) ? 2'b10 : 2'b00;
                b_issued++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        model_ptr   = BASE;
        model_wraps = 0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic clear_logs();
        in_q.delete();
        w_q.delete();
        wl_q.delete();
        aw_addr_q.delete();
        aw_len_q.delete();
    endtask

    task automatic send(input int n, input bit gaps);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 3000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = $urandom;
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        check("samples_sent", 64'(sent), 64'(n));
    endtask

    task automatic wait_bursts(input int target);
        int cyc;
        cyc = 0;
        while (b_cnt < target && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        check("burst_wait", 64'(b_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    // Bursts are full length except possibly the last; addresses follow the ring rule.
    task automatic verify_bursts(input int nb, input int last_len);
        int beats;
        int exp_len;
        int pos;
        bit exp_last[$];
        check("aw_count", 64'(aw_addr_q.size()), 64'(nb));
        for (int i = 0; i < nb; i++) begin
            exp_len = (i == nb - 1) ? last_len : BL - 1;
            if (i < aw_addr_q.size()) begin
                check("awaddr", 64'(aw_addr_q[i]), 64'(model_ptr));
                check("awlen", 64'(aw_len_q[i]), 64'(exp_len));
            end
            for (int b = 0; b <= exp_len; b++) exp_last.push_back(b == exp_len);
            model_ptr = model_ptr + 32'((exp_len + 1) * 4);
            if (model_ptr == BASE + RING) begin
                model_ptr = BASE;
                model_wraps++;
            end
        end
        beats = exp_last.size();
        check("beat_count", 64'(w_q.size()), 64'(beats));
        pos = 0;
        for (int i = 0; i < beats && i < w_q.size() && i < in_q.size(); i++) begin
            check("wdata_order", 64'(w_q[i]), 64'(in_q[i]));
            check("wlast_pos", 64'(wl_q[i]), 64'(exp_last[i]));
            pos++;
        end
        check("beats_compared", 64'(pos), 64'(beats));
    endtask

    initial begin
        int b0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
        model_ptr = BASE; model_wraps = 0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_wr_ptr", 64'(wr_ptr), 64'(BASE));
        check("rst_wrap_cnt", 64'(wrap_cnt), 64'd0);
        check("rst_flags", 64'({overflow, resp_err}), 64'd0);
        check("const_attrs", 64'({awsize, awburst, awcache, wstrb}), 64'({3'd2, 2'b01, 4'b0011, 4'hF}));
        tick(1);

        // 80 back-to-back samples, slave always ready: five bursts, the fifth after a wrap.
        clear_logs();
        b0 = b_cnt;
        pulse_start();
        send(80, 1'b0);
        wait_bursts(b0 + 5);
        tick(2);
        verify_bursts(5, BL - 1);
        check("wrap_wr_ptr", 64'(wr_ptr), 64'(model_ptr));
        check("wrap_cnt", 64'(wrap_cnt), 64'(model_wraps));
        check("running_busy", 64'(busy), 64'd1);
        pulse_stop();
        wait_idle();

        // Delayed AW and toggling W ready with gappy input.
        clear_logs();
        aw_delay = 5;
        w_toggle = 1'b1;
        b0 = b_cnt;
        pulse_start();
        check("start_resets_ptr", 64'(wr_ptr), 64'(BASE));
        send(48, 1'b1);
        wait_bursts(b0 + 3);
        tick(2);
        verify_bursts(3, BL - 1);
        check("aw_stable", 64'(aw_unstable), 64'd0);
        pulse_stop();
        wait_idle();
        aw_delay = 0;
        w_toggle = 1'b0;

        // SLVERR on the second burst: flag set, pointer advances, capture continues.
        clear_logs();
        b0 = b_cnt;
        err_at = b0 + 1;
        pulse_start();
        send(48, 1'b1);
        wait_bursts(b0 + 3);
        tick(2);
        verify_bursts(3, BL - 1);
        check("resp_err_set", 64'(resp_err), 64'd1);
        check("err_third_addr", 64'(aw_addr_q.size() > 2 ? aw_addr_q[2] : 32'h0), 64'(BASE + 32'h80));
        check("err_still_busy", 64'(busy), 64'd1);
        pulse_stop();
        wait_idle();
        check("resp_err_sticky", 64'(resp_err), 64'd1);
        err_at = -1;

        // W stalled while streaming: FIFO fills to depth, overflow latches.
        clear_logs();
        w_stall = 1'b1;
        b0 = b_cnt;
        pulse_start();
        check("start_clears_resp_err", 64'(resp_err), 64'd0);
        for (int i = 0; i < 120; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick(1);
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("fifo_fill", 64'(in_q.size()), 64'd64);
        check("full_s_ready", 64'(s_ready), 64'd0);
        check("overflow_set", 64'(overflow), 64'd1);
        tick(1);
        w_stall = 1'b0;
        wait_bursts(b0 + 4);
        tick(2);
        verify_bursts(4, BL - 1);
        check("overflow_sticky", 64'(overflow), 64'd1);
        pulse_stop();
        wait_idle();
        check("overflow_idle", 64'(overflow), 64'd1);
        pulse_start();
        check("start_clears_overflow", 64'(overflow), 64'd0);
        pulse_stop();
        wait_idle();

        // Stop with five residual samples after one full burst.
        clear_logs();
        b0 = b_cnt;
        pulse_start();
        send(21, 1'b1);
        wait_bursts(b0 + 1);
        tick(1);
        pulse_stop();
        wait_idle();
        tick(2);
`ifdef ADC_AXI_WR_FLUSH_EN
        verify_bursts(2, 4);
        check("flush_wr_ptr", 64'(wr_ptr), 64'(model_ptr));
`else
        verify_bursts(1, BL - 1);
        check("residual_dropped", 64'(in_q.size() - w_q.size()), 64'd5);
`endif

        // Reset while a burst is stuck in its data phase.
        clear_logs();
        b0 = b_cnt;
        pulse_start();
        err_at = b0;
        send(16, 1'b0);
        wait_bursts(b0 + 1);
        w_stall = 1'b1;
        send(16, 1'b0);
        begin
            int cyc;
            cyc = 0;
            while (!wvalid && cyc < 500) begin
                tick(1);
                cyc++;
            end
        end
        check("pre_rst_wvalid", 64'(wvalid), 64'd1);
        check("pre_rst_resp_err", 64'(resp_err), 64'd1);
        check("pre_rst_wr_ptr", 64'(wr_ptr), 64'(BASE + 32'h40));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valids", 64'({awvalid, wvalid, bready, s_ready}), 64'd0);
        check("mid_rst_wr_ptr", 64'(wr_ptr), 64'(BASE));
        check("mid_rst_flags", 64'({wrap_cnt, overflow, resp_err}), 64'd0);
        w_stall = 1'b0;
        err_at = -1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
